// File: rtl/decode_inst_queue.sv
// decode_inst_queue
//   Instruction queue between fetch and the decoder_ctrl instances of the
//   multi-issue front end. Accepts up to PUSH_W instructions per cycle and
//   presents up to POP_W head entries in program order. Every entry carries a
//   pre-decoded is_branch flag and an in_delay_slot tag. A branch is never
//   presented unless its delay-slot instruction is presented beside it.
//
//   Optional build macro: DECODE_QUEUE_STATS_EN adds the saturating
//   stat_full_cycles / stat_empty_cycles counters (cleared by rst only).
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   flush           discard all entries; wins over same-cycle push/pop
//   in_valid        per-lane push valid, contiguous from lane 0
//   in_inst         pushed instructions, lane 0 = oldest
//   in_pc           PC of lane 0; lane k is in_pc + 4k
//   in_ready        at least PUSH_W free entries (pre-pop count)
//   out_valid       presented head slots, contiguous from slot 0
//   out_inst/out_pc head instructions and PCs (zero when slot not valid)
//   out_is_branch   slot holds a branch/jump
//   out_delay_slot  slot holds a delay-slot instruction
//   pop_count       entries consumed this cycle
//   count           occupancy

// Branch/jump pre-decode for one pushed lane.
module decode_inst_queue_predecode (
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic       is_branch
);
   always_comb begin
      is_branch = (opcode == 6'b000001) || (opcode == 6'b000010) ||
                  (opcode == 6'b000011) || (opcode[5:2] == 4'b0001) ||
                  ((opcode == 6'b000000) &&
                   ((funct == 6'b001000) || (funct == 6'b001001)));
   end
endmodule

module decode_inst_queue #(
   parameter int DEPTH  = 8,
   parameter int PUSH_W = 2,
   parameter int POP_W  = 2,
   parameter int PC_W   = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             flush,
   input  logic [PUSH_W-1:0]                in_valid,
   input  logic [PUSH_W-1:0][31:0]          in_inst,
   input  logic [PC_W-1:0]                  in_pc,
   output logic                             in_ready,
   output logic [POP_W-1:0]                 out_valid,
   output logic [POP_W-1:0][31:0]           out_inst,
   output logic [POP_W-1:0][PC_W-1:0]       out_pc,
   output logic [POP_W-1:0]                 out_is_branch,
   output logic [POP_W-1:0]                 out_delay_slot,
   input  logic [$clog2(POP_W+1)-1:0]       pop_count,
   output logic [$clog2(DEPTH+1)-1:0]       count
`ifdef DECODE_QUEUE_STATS_EN
   ,
   output logic [31:0]                      stat_full_cycles,
   output logic [31:0]                      stat_empty_cycles
`endif
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int NW = $clog2(POP_W+1);

   logic [31:0]     mem_inst [DEPTH];
   logic [PC_W-1:0] mem_pc   [DEPTH];
   logic            mem_br   [DEPTH];
   logic            mem_ds   [DEPTH];

   logic [PW-1:0]   head, tail;
   logic            last_branch;

   logic [PUSH_W-1:0]          lane_br, lane_ds;
   logic [PUSH_W-1:0][PW-1:0]  wr_idx;
   logic [CW-1:0]              n_push;
   logic                       young_br, push_en;

   logic [POP_W:0]             avail;     // top bit stays 0: slot POP_W never presentable
   logic [POP_W-1:0][PW-1:0]   rd_idx;
   logic [NW-1:0]              n_valid, n_pop;

   // Per-lane pre-decode; a lane's delay-slot tag is the branch flag of the
   // entry pushed just before it (previous lane, or last push for lane 0).
   for (genvar k = 0; k < PUSH_W; k++) begin : g_lane
      decode_inst_queue_predecode u_pd (
         .opcode    (in_inst[k][31:26]),
         .funct     (in_inst[k][5:0]),
         .is_branch (lane_br[k])
      );
      if (k == 0) begin : g_first
         assign lane_ds[k] = last_branch;
      end else begin : g_next
         assign lane_ds[k] = lane_br[k-1];
      end
      assign wr_idx[k] = tail + PW'(k);
   end

   always_comb begin
      n_push   = '0;
      young_br = last_branch;
      for (int k = 0; k < PUSH_W; k++) begin
         if (in_valid[k]) begin
            n_push   = n_push + CW'(1);
            young_br = lane_br[k];
         end
      end
   end

   // Ready looks at the pre-pop occupancy only; no pop-to-push bypass.
   assign in_ready = (count <= CW'(DEPTH - PUSH_W));
   assign push_en  = in_ready & in_valid[0] & ~flush;

   // Presentation straight from storage. The youngest available slot is
   // withheld if it is a branch, since its delay slot is then either not in
   // the queue or beyond the window. With a single output slot a branch is
   // allowed to go alone.
   always_comb begin
      avail   = '0;
      n_valid = '0;
      for (int i = 0; i < POP_W; i++)
         avail[i] = (CW'(i) < count);
      for (int i = 0; i < POP_W; i++) begin
         rd_idx[i]    = head + PW'(i);
         out_valid[i] = avail[i];
         if ((POP_W > 1) && mem_br[rd_idx[i]] && !avail[i+1])
            out_valid[i] = 1'b0;
         out_inst[i]       = out_valid[i] ? mem_inst[rd_idx[i]] : '0;
         out_pc[i]         = out_valid[i] ? mem_pc[rd_idx[i]]   : '0;
         out_is_branch[i]  = out_valid[i] & mem_br[rd_idx[i]];
         out_delay_slot[i] = out_valid[i] & mem_ds[rd_idx[i]];
         if (out_valid[i])
            n_valid = n_valid + NW'(1);
      end
   end

   // Over-sized pops are clamped to what is actually presented.
   assign n_pop = (pop_count > n_valid) ? n_valid : pop_count;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         last_branch <= 1'b0;
      end else begin
         head  <= head + PW'(n_pop);
         count <= count + (push_en ? n_push : CW'(0)) - CW'(n_pop);
         if (push_en) begin
            tail        <= tail + PW'(n_push);
            last_branch <= young_br;
         end
      end
   end

   // Payload storage, no reset needed: validity lives in head/count.
   always_ff @(posedge clk) begin
      if (push_en && !rst) begin
         for (int k = 0; k < PUSH_W; k++) begin
            if (in_valid[k]) begin
               mem_inst[wr_idx[k]] <= in_inst[k];
               mem_pc[wr_idx[k]]   <= in_pc + PC_W'(4 * k);
               mem_br[wr_idx[k]]   <= lane_br[k];
               mem_ds[wr_idx[k]]   <= lane_ds[k];
            end
         end
      end
   end

`ifdef DECODE_QUEUE_STATS_EN
   // Saturating occupancy statistics; survive flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_full_cycles  <= '0;
         stat_empty_cycles <= '0;
      end else begin
         if ((count == CW'(DEPTH)) && (stat_full_cycles != '1))
            stat_full_cycles <= stat_full_cycles + 32'd1;
         if ((count == '0) && (stat_empty_cycles != '1))
            stat_empty_cycles <= stat_empty_cycles + 32'd1;
      end
   end
`else
   // Statistics counters compiled out.
`endif

   a_in_valid_contig: assert property (@(posedge clk) disable iff (rst)
      (in_valid & (in_valid + PUSH_W'(1))) == '0);
   a_pop_legal: assert property (@(posedge clk) disable iff (rst || flush)
      pop_count <= n_valid);

endmodule

// File: tb/tb_decode_inst_queue.sv
// tb_decode_inst_queue
//   Scoreboarded bench for decode_inst_queue (default build). The driver
//   issues stimulus and pushes expected entries into a queue; the monitor
//   pops and compares every entry the DUT hands over via pop_count.
module tb_decode_inst_queue;
   localparam int DEPTH = 8, PUSH_W = 2, POP_W = 2, PC_W = 32;

   localparam logic [31:0] ADDU  = 32'h00851021;
   localparam logic [31:0] LW    = 32'h8C820000;
   localparam logic [31:0] BEQ   = 32'h10850003;
   localparam logic [31:0] ADDIU = 32'h24420001;
   localparam logic [31:0] JAL   = 32'h0C000040;

   logic                     clk = 1'b0;
   logic                     rst, flush, in_ready;
   logic [PUSH_W-1:0]        in_valid;
   logic [PUSH_W-1:0][31:0]  in_inst;
   logic [PC_W-1:0]          in_pc;
   logic [POP_W-1:0]         out_valid, out_is_branch, out_delay_slot;
   logic [POP_W-1:0][31:0]   out_inst;
   logic [POP_W-1:0][PC_W-1:0] out_pc;
   logic [1:0]               pop_count;
   logic [3:0]               count;

   decode_inst_queue #(.DEPTH(DEPTH), .PUSH_W(PUSH_W), .POP_W(POP_W), .PC_W(PC_W)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_inst(in_inst),
      .in_pc(in_pc), .in_ready(in_ready), .out_valid(out_valid), .out_inst(out_inst),
      .out_pc(out_pc), .out_is_branch(out_is_branch), .out_delay_slot(out_delay_slot),
      .pop_count(pop_count), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        br;
      logic        ds;
   } ent_t;

   ent_t exp_q[$];
   bit   last_br;
   int   tests, fails;
   ent_t mon_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Branch classes from the opcode/funct table.
   function automatic bit is_br_f(input logic [31:0] x);
      logic [5:0] op;
      op = x[31:26];
      return (op inside {6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7}) ||
             (op == 6'd0 && (x[5:0] inside {6'd8, 6'd9}));
   endfunction

   // Slots the queue should present: head entries up to POP_W, minus a
   // trailing branch whose delay slot cannot be shown with it.
   function automatic int exp_nvalid();
      int n;
      n = (exp_q.size() < POP_W) ? exp_q.size() : POP_W;
      if (n > 0 && exp_q[n-1].br) n--;
      return n;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] x;
      x = $urandom;
      case ($urandom_range(0, 11))
         0: x[31:26] = 6'd4;
         1: x[31:26] = 6'd3;
         2: begin x[31:26] = 6'd0; x[5:0] = 6'd8; end
         3: begin x[31:26] = 6'd0; x[5:0] = 6'd9; end
         4: x[31:26] = 6'd1;
         5: x[31:26] = 6'd2;
         6: begin x[31:26] = 6'd0; x[5:0] = 6'h21; end
         7: x[31:26] = 6'd9;
         default: ;
      endcase
      return x;
   endfunction

   // One cycle: check the settled state against the model, then drive.
   task automatic step(input bit fl, input logic [1:0] iv, input logic [31:0] i0,
                       input logic [31:0] i1, input logic [31:0] pc, input int pn);
      int  nv;
      bit  rdy;
      ent_t e;
      logic [31:0] li [2];
      @(negedge clk);
      nv  = exp_nvalid();
      rdy = (DEPTH - exp_q.size()) >= PUSH_W;
      chk("count", 64'(count), 64'(exp_q.size()));
      chk("in_ready", 64'(in_ready), 64'(rdy));
      chk("out_valid", 64'(out_valid), 64'((1 << nv) - 1));
      if (pn > nv) pn = nv;
      flush = fl; in_valid = iv; in_inst[0] = i0; in_inst[1] = i1; in_pc = pc;
      pop_count = 2'(pn);
      li[0] = i0; li[1] = i1;
      if (fl) begin
         exp_q.delete();
         last_br = 1'b0;
      end else if (iv[0] && rdy) begin
         for (int k = 0; k < PUSH_W; k++) begin
            if (iv[k]) begin
               e.inst = li[k];
               e.pc   = pc + 32'(4 * k);
               e.br   = is_br_f(li[k]);
               e.ds   = (k == 0) ? last_br : is_br_f(li[k-1]);
               exp_q.push_back(e);
            end
         end
         last_br = exp_q[exp_q.size()-1].br;
      end
   endtask

   // Monitor: every consumed slot must match the next expected entry.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst && !flush) begin
            for (int i = 0; i < int'(pop_count); i++) begin
               if (exp_q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL pop_underflow: slot %0d popped, expected queue empty", i);
               end else begin
                  mon_e = exp_q.pop_front();
                  chk("out_inst",  64'(out_inst[i]),       64'(mon_e.inst));
                  chk("out_pc",    64'(out_pc[i]),         64'(mon_e.pc));
                  chk("out_is_br", 64'(out_is_branch[i]),  64'(mon_e.br));
                  chk("out_ds",    64'(out_delay_slot[i]), 64'(mon_e.ds));
               end
            end
         end
      end
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = '0; in_inst = '0; in_pc = '0; pop_count = '0;
      last_br = 1'b0; tests = 0; fails = 0;
      repeat (3) @(negedge clk);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_pc", 64'(out_pc), 64'd0);
      chk("rst_out_inst", 64'(out_inst), 64'd0);
      rst = 1'b0;

      // addu,lw at 0x100: both presented, no delay-slot tags.
      step(0, 2'b11, ADDU, LW, 32'h100, 0);
      step(0, 2'b00, 0, 0, 0, 2);

      // Branch as youngest entry is held until its delay slot arrives.
      step(0, 2'b11, ADDU, BEQ, 32'h200, 0);
      step(0, 2'b00, 0, 0, 0, 1);
      step(0, 2'b00, 0, 0, 0, 0);
      step(0, 2'b01, ADDIU, 0, 32'h208, 0);
      step(0, 2'b00, 0, 0, 0, 2);

      // Fill to full, push while full is dropped, pop with push at full.
      step(1, 2'b00, 0, 0, 0, 0);
      for (int j = 0; j < 4; j++) step(0, 2'b11, ADDU, LW, 32'h300 + 32'(8 * j), 0);
      step(0, 2'b11, ADDU, ADDU, 32'h380, 0);
      step(0, 2'b11, ADDU, ADDU, 32'h390, 2);
      step(0, 2'b11, ADDU, ADDU, 32'h3A0, 2);
      step(0, 2'b00, 0, 0, 0, 0);

      // Flush with a jal pending as last push: no tag survives.
      step(1, 2'b00, 0, 0, 0, 0);
      step(0, 2'b11, ADDU, ADDU, 32'h400, 0);
      step(0, 2'b11, ADDU, ADDU, 32'h408, 0);
      step(0, 2'b01, JAL, 0, 32'h410, 0);
      step(1, 2'b11, ADDU, ADDU, 32'h500, 0);
      step(0, 2'b11, ADDU, ADDU, 32'h600, 0);
      step(0, 2'b00, 0, 0, 0, 2);

      // Random mixed traffic; wraps the pointers many times.
      for (int j = 0; j < 3000; j++) begin
         logic [1:0] iv;
         case ($urandom_range(0, 3))
            0: iv = 2'b00;
            1: iv = 2'b01;
            default: iv = 2'b11;
         endcase
         step(($urandom_range(0, 99) < 2), iv, rand_inst(), rand_inst(),
              {$urandom, 2'b00}, int'($urandom_range(0, 2)));
      end
      step(0, 2'b00, 0, 0, 0, 0);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
